tl_req_mux_queue: RTL and testbench
===================================

Name: tl_req_mux_queue

Overview:
- Multi-source TileLink A-channel request queue: N_SRC requesters contend through a round-robin arbiter into one shared FIFO of depth FIFO_DEPTH.
- Sits in front of the MPU. Each accepted request is tagged with its source index so responses can be routed back.
- Adds per-source valid/ready handshake, correct simultaneous enqueue/dequeue, non-power-of-two depth, occupancy/almost-full status and synchronous flush.

Parameters:
- N_SRC, 2, number of requester channels (>=1).
- FIFO_DEPTH, 6, number of entries (>=2, need not be a power of two).
- AFULL_THRESH, FIFO_DEPTH-1, occupancy at or above which almost_full asserts (1..FIFO_DEPTH).
- PTR_BITS, $clog2(FIFO_DEPTH), head/tail pointer width.
- SRC_BITS, (N_SRC>1)?$clog2(N_SRC):1, source tag width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_req  in  tl_a_channel[N_SRC]  per-source request; the .valid field is that source's valid
- in_rdy  out  N_SRC  per-source ready; at most one bit high per cycle
- flush  in  1  synchronous queue clear
- out_req  out  tl_a_channel  head entry; '0 when empty
- out_src  out  SRC_BITS  source tag of head entry; 0 when empty
- out_valid  out  1  queue non-empty
- out_ready  in  1  consumer accepts head this cycle
- mpu_cs  out  1  equals out_valid
- count  out  PTR_BITS+1  current occupancy
- almost_full  out  1  count >= AFULL_THRESH

Behaviour:
- Reset (async, immediate, no clock needed):
  - head=tail=count=0; rr_ptr=0; storage and tags cleared.
  - Outputs: out_valid=0, mpu_cs=0, out_req='0, out_src=0, count=0, almost_full=0 (unless AFULL_THRESH=0, disallowed). in_rdy follows its combinational rule.
  - Reset mid-operation discards all contents; the first post-reset edge behaves as from empty.
- Arbitration:
  - Combinational round-robin over sources with in_req[i].valid, searching from rr_ptr upward with wrap. The winner is g.
  - in_rdy[g] = (count < FIFO_DEPTH) && !flush; all other in_rdy bits are 0.
  - Ready must not depend on out_ready (no combinational path through the queue).
- Enqueue fires when in_req[g].valid && in_rdy[g]:
  - storage[head] <= in_req[g]; tag[head] <= g; head advances.
  - rr_ptr <= (g==N_SRC-1) ? 0 : g+1.
  - rr_ptr holds when nothing fires, including a stall due to full.
- Dequeue fires when out_valid && out_ready: tail advances. Zero latency; the head is visible in the same cycle (first-word-fall-through).
- Pointer wrap: a pointer at FIFO_DEPTH-1 advances to 0 explicitly. No reliance on modulo-2^PTR_BITS.
- Occupancy:
  - Enqueue only: count+1. Dequeue only: count-1. Both: count unchanged, both pointers advance.
  - Empty with a same-cycle enqueue: no bypass; the entry appears at the output next cycle (1-cycle enqueue-to-output latency).
  - Full with out_ready=1: in_rdy stays 0 that cycle; the dequeue proceeds; enqueue is accepted next cycle.
- flush:
  - Next edge: head=tail=count=0. Enqueue blocked via in_rdy. A coincident dequeue is ignored for state (the consumer may still see the handshake; the data is discarded).
  - Storage is not cleared. rr_ptr is unchanged.
- Outputs out_req, out_src and out_valid derive combinationally from tail and count.
- almost_full and count are registered-state derived, so there is no combinational input path.
- Assertions (simulation only):
  - in_rdy is one-hot or zero.
  - count never exceeds FIFO_DEPTH.
  - No dequeue when count==0.

Decomposition:
- Shared package mpu_common: tl_a_channel (existing).
- New in mpu_common: localparam REQQ_MAX_SRC=8 and a function rr_next(idx,n) for wrap increment.
- Source tag is stored in a separate tag array, since its width is parameter-dependent; it is not a package struct.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], base[SRC_BITS].
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational.

Test Plan:
- Reset then idle -> out_valid=0, out_req='0, count=0, almost_full=0, in_rdy[0]=0. Assert rst mid-stream with 3 entries -> count=0 and out_valid=0 before the next clk edge.
- N_SRC=2, both valid every cycle, out_ready=0 -> accepted order src0,src1,src0,src1,src0,src1. count reaches 6, then in_rdy=0 and almost_full=1 from count=5. out_src sequence on drain is 0,1,0,1,0,1.
- FIFO_DEPTH=6, push 4 then pop 4 repeatedly for 3 rounds -> data matches order across the head/tail wrap 5->0. count never exceeds 4.
- Full (count=6) with out_ready=1 and src1 valid -> that cycle dequeues, count=5, in_rdy[1]=0. Next cycle src1 is accepted and count stays 5 (simultaneous enq+deq).
- count=3 with flush=1 and src0 valid -> in_rdy=0. Next cycle count=0 and out_valid=0. The following push appears as the head with out_src=0.
- Only src1 valid for 4 cycles, then both valid -> src1 wins 4 times, rr_ptr=0, so src0 wins the next grant (no starvation).

Source files
------------

// File: rtl/mpu_common.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpu_common : types and helpers shared by the MPU request path        |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package mpu_common;

    localparam int REQQ_MAX_SRC = 8;

    typedef struct packed {
        logic        valid;
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_channel;

    // Increment with explicit wrap at n-1; used for pointers and the RR base.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_req_mux_queue_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at base         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N        = 2,
    parameter int SRC_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [SRC_BITS-1:0] base,
    output logic                gnt_valid,
    output logic [SRC_BITS-1:0] gnt_idx
);

    int w_idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            // Descending scan so the lowest offset from base wins last.
            w_idx = int'(base) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SRC_BITS'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_req_mux_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_req_mux_queue : N-source TL-A request arbiter feeding a FWFT FIFO |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tl_req_mux_queue
    import mpu_common::*;
#(
    parameter int N_SRC        = 2,
    parameter int FIFO_DEPTH   = 6,
    parameter int AFULL_THRESH = FIFO_DEPTH - 1,
    parameter int PTR_BITS     = $clog2(FIFO_DEPTH),
    parameter int SRC_BITS     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  tl_a_channel [N_SRC-1:0] in_req,
    output logic [N_SRC-1:0]        in_rdy,
    input  logic                    flush,
    output tl_a_channel             out_req,
    output logic [SRC_BITS-1:0]     out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    mpu_cs,
    output logic [PTR_BITS:0]       count,
    output logic                    almost_full
);

    localparam logic [PTR_BITS:0] c_depth   = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS:0] c_afull   = (PTR_BITS + 1)'(AFULL_THRESH);
    localparam logic [PTR_BITS:0] c_cnt_one = (PTR_BITS + 1)'(1);

    if (N_SRC > REQQ_MAX_SRC) begin : g_bad_nsrc
        $error("N_SRC exceeds REQQ_MAX_SRC");
    end

    tl_a_channel         r_mem [FIFO_DEPTH];
    logic [SRC_BITS-1:0] r_tag [FIFO_DEPTH];
    logic [PTR_BITS-1:0] r_head;
    logic [PTR_BITS-1:0] r_tail;
    logic [PTR_BITS:0]   r_count;
    logic [SRC_BITS-1:0] r_rr_ptr;

    logic [N_SRC-1:0]    w_req_valid;
    logic                w_gnt_valid;
    logic [SRC_BITS-1:0] w_gnt_idx;
    logic                w_enq_ok;
    logic                w_enq;
    logic                w_deq;

    for (genvar i = 0; i < N_SRC; i++) begin : g_req_valid
        assign w_req_valid[i] = in_req[i].valid;
    end

    rr_arbiter #(
        .N        (N_SRC),
        .SRC_BITS (SRC_BITS)
    ) u_arb (
        .req       (w_req_valid),
        .base      (r_rr_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Ready is a function of registered occupancy and flush only.
    assign w_enq_ok = (r_count < c_depth) && !flush;
    assign w_enq    = w_gnt_valid && w_enq_ok;
    assign w_deq    = out_valid && out_ready;

    always_comb begin
        in_rdy = '0;
        if (w_enq) begin
            in_rdy[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_head] <= in_req[w_gnt_idx];
                r_tag[r_head] <= w_gnt_idx;
                r_head        <= PTR_BITS'(rr_next(32'(r_head), FIFO_DEPTH));
                r_rr_ptr      <= SRC_BITS'(rr_next(32'(w_gnt_idx), N_SRC));
            end
            if (w_deq) begin
                r_tail <= PTR_BITS'(rr_next(32'(r_tail), FIFO_DEPTH));
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_req     = out_valid ? r_mem[r_tail] : '0;
    assign out_src     = out_valid ? r_tag[r_tail] : '0;
    assign mpu_cs      = out_valid;
    assign count       = r_count;
    assign almost_full = (r_count >= c_afull);

    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(in_rdy));
    a_count_max   : assert property (@(posedge clk) disable iff (rst) r_count <= c_depth);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) w_deq |-> (r_count != '0));

endmodule
`default_nettype wire

// File: tb/tb_tl_req_mux_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tl_req_mux_queue : directed self-checking bench (N_SRC=2, D=6)    |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_tl_req_mux_queue;
    import mpu_common::*;

    logic              clk = 1'b0;
    logic              rst;
    tl_a_channel [1:0] in_req;
    logic [1:0]        in_rdy;
    logic              flush;
    tl_a_channel       out_req;
    logic [0:0]        out_src;
    logic              out_valid;
    logic              out_ready;
    logic              mpu_cs;
    logic [3:0]        count;
    logic              almost_full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tl_req_mux_queue dut (
        .clk         (clk),
        .rst         (rst),
        .in_req      (in_req),
        .in_rdy      (in_rdy),
        .flush       (flush),
        .out_req     (out_req),
        .out_src     (out_src),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mpu_cs      (mpu_cs),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic tl_a_channel mk(input logic [31:0] a);
        tl_a_channel t;
        t         = '0;
        t.valid   = 1'b1;
        t.opcode  = 3'd4;
        t.address = a;
        t.mask    = 4'hF;
        t.data    = ~a;
        return t;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        int i0;
        int i1;
        int n;
        int m;
        rst       = 1'b1;
        in_req    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_cs", 128'(mpu_cs), 128'd0);
        check("rst_req", 128'(out_req), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_afull", 128'(almost_full), 128'd0);
        check("rst_rdy", 128'(in_rdy), 128'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Both sources valid every cycle, consumer stalled.
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            in_req[0] = mk(32'h100 + i0);
            in_req[1] = mk(32'h200 + i1);
            #1;
            check("fill_rdy", 128'(in_rdy), (c < 6) ? ((c % 2 == 0) ? 128'd1 : 128'd2) : 128'd0);
            check("fill_count", 128'(count), (c < 6) ? 128'(c) : 128'd6);
            check("fill_afull", 128'(almost_full), (c >= 5) ? 128'd1 : 128'd0);
            if (c < 6) begin
                if (c % 2 == 0) i0++; else i1++;
            end
            next_cycle();
        end
        in_req    = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("drain_valid", 128'(out_valid), 128'd1);
            check("drain_src", 128'(out_src), 128'(k % 2));
            check("drain_addr", 128'(out_req.address), 128'((k % 2 == 1 ? 32'h200 : 32'h100) + 32'(k / 2)));
            next_cycle();
        end
        out_ready = 1'b0;
        #1;
        check("drain_empty", 128'(out_valid), 128'd0);
        check("drain_req0", 128'(out_req), 128'd0);

        // Push 4 / pop 4 over three rounds to exercise the 5->0 wrap.
        n = 0;
        m = 0;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                in_req[0] = mk(32'h300 + n);
                in_req[1] = '0;
                #1;
                check("wrap_rdy", 128'(in_rdy), 128'd1);
                n++;
                next_cycle();
            end
            in_req    = '0;
            out_ready = 1'b1;
            for (int p = 0; p < 4; p++) begin
                #1;
                check("wrap_addr", 128'(out_req.address), 128'(32'h300 + m));
                check("wrap_count", 128'(count), 128'(4 - p));
                m++;
                next_cycle();
            end
            out_ready = 1'b0;
        end

        // Full with consumer ready: dequeue now, enqueue next cycle.
        for (int p = 0; p < 6; p++) begin
            in_req[0] = mk(32'h400 + p);
            next_cycle();
        end
        in_req[0] = '0;
        in_req[1] = mk(32'h500);
        out_ready = 1'b1;
        #1;
        check("full_count", 128'(count), 128'd6);
        check("full_rdy", 128'(in_rdy), 128'd0);
        check("full_afull", 128'(almost_full), 128'd1);
        check("full_head", 128'(out_req.address), 128'h400);
        next_cycle();
        #1;
        check("full_count5", 128'(count), 128'd5);
        check("full_rdy1", 128'(in_rdy), 128'd2);
        check("full_head1", 128'(out_req.address), 128'h401);
        next_cycle();
        in_req[1] = '0;
        #1;
        check("simul_count", 128'(count), 128'd5);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("full_drain_addr", 128'(out_req.address), (k < 4) ? 128'(32'h402 + k) : 128'h500);
            check("full_drain_src", 128'(out_src), (k < 4) ? 128'd0 : 128'd1);
            next_cycle();
        end
        out_ready = 1'b0;
        #1;
        check("full_drain_cnt", 128'(count), 128'd0);

        // Flush with three entries queued.
        for (int p = 0; p < 3; p++) begin
            in_req[0] = mk(32'h600 + p);
            next_cycle();
        end
        flush     = 1'b1;
        in_req[0] = mk(32'h6FF);
        #1;
        check("flush_rdy", 128'(in_rdy), 128'd0);
        check("flush_count", 128'(count), 128'd3);
        next_cycle();
        flush     = 1'b0;
        in_req[0] = mk(32'h650);
        #1;
        check("flush_cnt0", 128'(count), 128'd0);
        check("flush_valid0", 128'(out_valid), 128'd0);
        check("flush_req0", 128'(out_req), 128'd0);
        check("post_flush_rdy", 128'(in_rdy), 128'd1);
        next_cycle();
        in_req = '0;
        #1;
        check("post_flush_valid", 128'(out_valid), 128'd1);
        check("post_flush_src", 128'(out_src), 128'd0);
        check("post_flush_addr", 128'(out_req.address), 128'h650);
        out_ready = 1'b1;
        next_cycle();
        #1;
        check("post_flush_empty", 128'(count), 128'd0);

        // Only src1 valid for four grants, then both: src0 must win.
        for (int p = 0; p < 4; p++) begin
            in_req[0] = '0;
            in_req[1] = mk(32'h800 + p);
            #1;
            check("starve_rdy1", 128'(in_rdy), 128'd2);
            next_cycle();
        end
        in_req[0] = mk(32'h900);
        in_req[1] = mk(32'h8FF);
        #1;
        check("starve_rdy0", 128'(in_rdy), 128'd1);
        check("starve_head_src", 128'(out_src), 128'd1);
        next_cycle();
        in_req = '0;
        #1;
        check("starve_src0", 128'(out_src), 128'd0);
        check("starve_addr0", 128'(out_req.address), 128'h900);
        next_cycle();
        out_ready = 1'b0;
        #1;
        check("starve_empty", 128'(count), 128'd0);

        // Asynchronous reset with three entries queued.
        for (int p = 0; p < 3; p++) begin
            in_req[0] = mk(32'hA00 + p);
            next_cycle();
        end
        in_req = '0;
        #1;
        check("mid_count3", 128'(count), 128'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 128'(count), 128'd0);
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_afull", 128'(almost_full), 128'd0);
        next_cycle();
        rst       = 1'b0;
        in_req[0] = mk(32'hB01);
        in_req[1] = mk(32'hB00);
        #1;
        check("post_rst_rdy", 128'(in_rdy), 128'd1);
        next_cycle();
        in_req = '0;
        #1;
        check("post_rst_src", 128'(out_src), 128'd0);
        check("post_rst_addr", 128'(out_req.address), 128'hB01);
        check("post_rst_count", 128'(count), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
